// File: rtl/ycr1_dmem_router_pkg.sv
// Shared dmem interface types: cmd/width/resp encodings, router target tags and timer window defaults.
// Optional feature macro: YCR1_DMEM_ROUTER_ERR_EN (adds an ERR tag, widening queue entries to 2 bits).
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

package ycr1_dmem_router_pkg;
  typedef enum logic {
    YCR1_MEM_CMD_RD = 1'b0,
    YCR1_MEM_CMD_WR = 1'b1
  } type_ycr1_mem_cmd_e;

  typedef enum logic [1:0] {
    YCR1_MEM_WIDTH_BYTE  = 2'b00,
    YCR1_MEM_WIDTH_HWORD = 2'b01,
    YCR1_MEM_WIDTH_WORD  = 2'b10
  } type_ycr1_mem_width_e;

  typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
  } type_ycr1_mem_resp_e;

  typedef enum logic [1:0] {
    TGT_EXT = 2'd0,
    TGT_TMR = 2'd1,
    TGT_ERR = 2'd2
  } ycr1_dmem_tgt_e;

  localparam logic [`YCR1_DMEM_AWIDTH-1:0] YCR1_TIMER_BASE_DEFAULT = 32'hF004_0000;
  localparam logic [`YCR1_DMEM_AWIDTH-1:0] YCR1_TIMER_MASK_DEFAULT = 32'hFFFF_FFE0;

`ifdef YCR1_DMEM_ROUTER_ERR_EN
  localparam int YCR1_DMEM_TAG_W = 2;
`else
  localparam int YCR1_DMEM_TAG_W = 1;
`endif
endpackage

// File: rtl/ycr1_dmem_router_if.sv
// One dmem request/response port; master drives the request, slave answers with ack and response.
interface ycr1_dmem_router_if;
  import ycr1_dmem_router_pkg::*;

  logic                          req;
  type_ycr1_mem_cmd_e            cmd;
  type_ycr1_mem_width_e          width;
  logic [`YCR1_DMEM_AWIDTH-1:0]  addr;
  logic [`YCR1_DMEM_DWIDTH-1:0]  wdata;
  logic                          req_ack;
  logic [`YCR1_DMEM_DWIDTH-1:0]  rdata;
  type_ycr1_mem_resp_e           resp;

  modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
  modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);
endinterface

// File: rtl/ycr1_dmem_router_q.sv
// In-order tag FIFO recording which target owns each outstanding request.
module ycr1_dmem_router_q #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    // Push and pop together leave occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/ycr1_dmem_router.sv
// LSU dmem router: timer window goes to p1, everything else to p0; responses return in issue order.
// Optional macro YCR1_DMEM_ROUTER_ERR_EN: malformed timer accesses are answered locally with RDY_ER.
module ycr1_dmem_router
  import ycr1_dmem_router_pkg::*;
#(
  parameter logic [`YCR1_DMEM_AWIDTH-1:0] TIMER_BASE = YCR1_TIMER_BASE_DEFAULT,
  parameter logic [`YCR1_DMEM_AWIDTH-1:0] TIMER_MASK = YCR1_TIMER_MASK_DEFAULT,
  parameter int                           PEND_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ycr1_dmem_router_if.slave  core,
  ycr1_dmem_router_if.master p0,
  ycr1_dmem_router_if.master p1
);
  logic                       in_win, bad_acc, req_ok;
  logic                       q_push, q_pop, q_full, q_empty;
  logic [YCR1_DMEM_TAG_W-1:0] q_head;
  logic [1:0]                 sel_w;
  ycr1_dmem_tgt_e             sel, head_tgt;

  assign in_win = ((core.addr & TIMER_MASK) == TIMER_BASE);
`ifdef YCR1_DMEM_ROUTER_ERR_EN
  // The timer acks sub-word/misaligned accesses but never answers them.
  assign bad_acc = in_win & ((core.width != YCR1_MEM_WIDTH_WORD) | (core.addr[1:0] != 2'b00));
`else
  assign bad_acc = 1'b0;
`endif
  assign sel    = bad_acc ? TGT_ERR : (in_win ? TGT_TMR : TGT_EXT);
  assign sel_w  = sel;
  // Fullness uses the registered count only, so resp never feeds req.
  assign req_ok = rst_n & core.req & ~q_full;

  assign p0.req   = req_ok & (sel == TGT_EXT);
  assign p1.req   = req_ok & (sel == TGT_TMR);
  assign p0.cmd   = core.cmd;
  assign p1.cmd   = core.cmd;
  assign p0.width = core.width;
  assign p1.width = core.width;
  assign p0.addr  = core.addr;
  assign p1.addr  = core.addr;
  assign p0.wdata = core.wdata;
  assign p1.wdata = core.wdata;

  assign q_push       = (p0.req & p0.req_ack) | (p1.req & p1.req_ack) | (req_ok & (sel == TGT_ERR));
  assign core.req_ack = q_push;

  ycr1_dmem_router_q #(.DEPTH(PEND_DEPTH), .W(YCR1_DMEM_TAG_W)) u_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (sel_w[YCR1_DMEM_TAG_W-1:0]),
    .pop   (q_pop),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign head_tgt = ycr1_dmem_tgt_e'(2'(q_head));

  // Only the head target is listened to; any other port's response is dropped.
  always_comb begin
    core.resp  = YCR1_MEM_RESP_NOTRDY;
    core.rdata = '0;
    if (!q_empty) begin
      unique case (head_tgt)
        TGT_EXT: begin
          core.resp  = p0.resp;
          core.rdata = p0.rdata;
        end
        TGT_TMR: begin
          core.resp  = p1.resp;
          core.rdata = p1.rdata;
        end
        default: core.resp = YCR1_MEM_RESP_RDY_ER;
      endcase
    end
  end

  assign q_pop = (core.resp != YCR1_MEM_RESP_NOTRDY);
endmodule
